// File: rtl/mult_pkg.sv
// mult_pkg: shared width constants and the counter-width helper for the shift-add multiplier datapath.
package mult_pkg;

    localparam int MULT_WIDTH = 16;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    localparam int MULT_CNT_W = cnt_width(MULT_WIDTH);

endpackage

// File: rtl/mult_bit_counter.sv
// mult_bit_counter: shift counter for the multiplier; k flags the last shift of an operation.
module mult_bit_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    input  logic inc,
    output logic k
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] cnt;

    always_ff @(posedge Clk) begin
        if (Rst || clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    assign k = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_datapath.sv
// mult_datapath: shift-add multiplier datapath driven by an external Load/Ad/Sh controller.
// Build option MULT_PRODUCT_REG_EN adds a registered Product with a one-cycle Valid pulse.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Load,
    input  logic                 Ad,
    input  logic                 Sh,
    input  logic [WIDTH-1:0]     Mcand,
    input  logic [WIDTH-1:0]     Mplier,
    output logic                 M,
    output logic                 K,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Valid
);

    logic [2*WIDTH:0] acc;
    logic [2*WIDTH:0] acc_add;
    logic [2*WIDTH:0] acc_nxt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mc;

    // Add lands in the upper half with its carry in the spare top bit, then the shift consumes it.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mc};
        acc_add = Ad ? {sum, acc[WIDTH-1:0]} : acc;
        acc_nxt = Load ? {{(WIDTH+1){1'b0}}, Mplier} : Sh ? {1'b0, acc_add[2*WIDTH:1]} : acc_add;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc <= '0;
            mc  <= '0;
        end else begin
            acc <= acc_nxt;
            if (Load)
                mc <= Mcand;
        end
    end

    mult_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .Clk (Clk),
        .Rst (Rst),
        .clr (Load),
        .inc (Sh),
        .k   (K)
    );

    assign M = acc[0];

`ifdef MULT_PRODUCT_REG_EN
    logic [2*WIDTH-1:0] prod_q;
    logic               done;

    assign done = Sh & K & ~Load;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            prod_q <= '0;
            Valid  <= 1'b0;
        end else begin
            Valid <= done;
            if (done)
                prod_q <= acc_nxt[2*WIDTH-1:0];
        end
    end

    assign Product = prod_q;
`else
    assign Product = acc[2*WIDTH-1:0];
    assign Valid   = 1'b0;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: vector table, hand sequences and random operands against an arithmetic model,
// on a WIDTH=4 instance plus a WIDTH=16 instance for the full-width corner.
module tb_mult_datapath;

    localparam int W = 4;
`ifdef MULT_PRODUCT_REG_EN
    localparam bit REG_EN = 1'b1;
`else
    localparam bit REG_EN = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Rst, Load, Ad, Sh;
    logic [3:0]   Mcand, Mplier;
    logic         M, K, Valid;
    logic [7:0]   Product;
    logic         Load16, Ad16, Sh16;
    logic [15:0]  Mcand16, Mplier16;
    logic         M16, K16, Valid16;
    logic [31:0]  Product16;

    int n_chk = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    mult_datapath #(.WIDTH(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .Load(Load), .Ad(Ad), .Sh(Sh),
        .Mcand(Mcand), .Mplier(Mplier), .M(M), .K(K), .Product(Product), .Valid(Valid)
    );

    mult_datapath #(.WIDTH(16)) dut16 (
        .Clk(Clk), .Rst(Rst), .Load(Load16), .Ad(Ad16), .Sh(Sh16),
        .Mcand(Mcand16), .Mplier(Mplier16), .M(M16), .K(K16), .Product(Product16), .Valid(Valid16)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        bit         sep;
        bit         tog;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Accumulator after i add/shift iterations: partial product of the low i multiplier bits
    // sitting above the not-yet-consumed multiplier bits.
    function automatic longint model_acc(input longint a, input longint b, input int i, input int w);
        return ((a * (b & ((longint'(1) << i) - 1))) << (w - i)) + (b >> i);
    endfunction

    task automatic run(input logic [3:0] a, input logic [3:0] b, input bit sep, input bit tog,
                       input logic [7:0] exp, input string tag);
        longint added;
        bit     m, saw_carry, exp_carry;
        saw_carry = 1'b0;
        exp_carry = 1'b0;
        Load = 1'b1; Mcand = a; Mplier = b; Ad = 1'b0; Sh = 1'b0;
        tick();
        Load = 1'b0;
        chk({tag, " load acc"}, 64'(dut4.acc), 64'(b));
        for (int i = 0; i < W; i++) begin
            if (tog) begin
                Mcand = 4'($urandom);
                Mplier = 4'($urandom);
            end
            m = b[i];
            chk($sformatf("%s M%0d", tag, i), 64'(M), 64'(m));
            chk($sformatf("%s K%0d", tag, i), 64'(K), 64'(i == W - 1));
            added = model_acc(a, b, i, W) + (m ? (longint'(a) << W) : 0);
            if (added >= 256) exp_carry = 1'b1;
            if (sep) begin
                Ad = m;
                tick();
                Ad = 1'b0;
                saw_carry |= dut4.acc[8];
                chk($sformatf("%s add%0d", tag, i), 64'(dut4.acc), 64'(added));
                Sh = 1'b1;
            end else begin
                Ad = m;
                Sh = 1'b1;
            end
            tick();
            Ad = 1'b0; Sh = 1'b0;
            chk($sformatf("%s sh%0d", tag, i), 64'(dut4.acc), 64'(model_acc(a, b, i + 1, W)));
            chk($sformatf("%s valid%0d", tag, i), 64'(Valid), 64'(REG_EN && i == W - 1));
        end
        chk({tag, " product"}, 64'(Product), 64'(exp));
        if (sep) chk({tag, " carry"}, 64'(saw_carry), 64'(exp_carry));
        tick();
        chk({tag, " valid after"}, 64'(Valid), 64'b0);
    endtask

    vec_t vt[7] = '{
        '{4'd13, 4'd11, 1'b1, 1'b0, 8'd143},
        '{4'd15, 4'd15, 1'b1, 1'b0, 8'd225},
        '{4'd0,  4'd9,  1'b1, 1'b0, 8'd0},
        '{4'd7,  4'd0,  1'b1, 1'b0, 8'd0},
        '{4'd3,  4'd5,  1'b0, 1'b0, 8'd15},
        '{4'd13, 4'd11, 1'b0, 1'b1, 8'd143},
        '{4'd15, 4'd1,  1'b1, 1'b1, 8'd15}
    };

    initial begin
        logic [3:0] ra, rb;
        Rst = 1'b1; Load = 1'b0; Ad = 1'b0; Sh = 1'b0; Mcand = '0; Mplier = '0;
        Load16 = 1'b0; Ad16 = 1'b0; Sh16 = 1'b0; Mcand16 = '0; Mplier16 = '0;
        tick();
        tick();
        Rst = 1'b0;
        chk("reset M", 64'(M), 64'b0);
        chk("reset K", 64'(K), 64'b0);
        chk("reset Product", 64'(Product), 64'b0);
        chk("reset Valid", 64'(Valid), 64'b0);

        foreach (vt[v])
            run(vt[v].a, vt[v].b, vt[v].sep, vt[v].tog, vt[v].exp, $sformatf("vec%0d", v));

        for (int i = 0; i < 3; i++) tick();
        chk("hold acc", 64'(dut4.acc), 64'd15);

        Load = 1'b1; Mcand = 4'd2; Mplier = 4'd3;
        tick();
        Load = 1'b0;
        chk("product across load", 64'(Product), REG_EN ? 64'd15 : 64'd3);

        Sh = 1'b1;
        tick();
        Load = 1'b1; Ad = 1'b1; Sh = 1'b1; Mcand = 4'd9; Mplier = 4'd6;
        tick();
        Load = 1'b0; Ad = 1'b0; Sh = 1'b0;
        chk("load priority cnt", 64'(dut4.u_cnt.cnt), 64'd0);
        chk("load priority acc", 64'(dut4.acc), 64'd6);
        chk("load priority M", 64'(M), 64'd0);

        Load = 1'b1; Mcand = 4'd13; Mplier = 4'd11;
        tick();
        Load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            Ad = M; Sh = 1'b1;
            tick();
        end
        chk("pre-reset acc", 64'(dut4.acc), 64'(model_acc(13, 11, 2, W)));
        Rst = 1'b1; Ad = 1'b1; Sh = 1'b1;
        tick();
        Rst = 1'b0; Ad = 1'b0; Sh = 1'b0;
        chk("midrst acc", 64'(dut4.acc), 64'd0);
        chk("midrst cnt", 64'(dut4.u_cnt.cnt), 64'd0);
        chk("midrst K", 64'(K), 64'b0);
        chk("midrst M", 64'(M), 64'b0);
        chk("midrst Product", 64'(Product), 64'd0);
        chk("midrst Valid", 64'(Valid), 64'b0);
        run(4'd3, 4'd5, 1'b1, 1'b0, 8'd15, "after reset");

        for (int r = 0; r < 30; r++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            run(ra, rb, 1'($urandom), 1'($urandom), 8'(ra * rb), $sformatf("rand%0d", r));
        end

        Load16 = 1'b1; Mcand16 = 16'hFFFF; Mplier16 = 16'hFFFF;
        tick();
        Load16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("w16 K%0d", i), 64'(K16), 64'(i == 15));
            Ad16 = M16; Sh16 = 1'b1;
            tick();
        end
        Ad16 = 1'b0; Sh16 = 1'b0;
        chk("w16 product", 64'(Product16), 64'h0000_0000_FFFE_0001);
        chk("w16 top bit", 64'(dut16.acc[32]), 64'b0);
        chk("w16 valid", 64'(Valid16), 64'(REG_EN));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_datapath.md
MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 Parameter: WIDTH, default 16, operand width N; legal range 2..32.
REQ-002 Port: Clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: Rst  input  1  reset, synchronous, active-high.
REQ-004 Port: Load  input  1  from multiplier controller; initialise datapath with new operands.
REQ-005 Port: Ad  input  1  from controller; add multiplicand into the upper accumulator half.
REQ-006 Port: Sh  input  1  from controller; shift the accumulator right one bit and advance the bit counter.
REQ-007 Port: Mcand  input  WIDTH  multiplicand, unsigned; sampled only on Load.
REQ-008 Port: Mplier  input  WIDTH  multiplier, unsigned; sampled only on Load.
REQ-009 Port: M  output  1  current multiplier LSB, ACC[0]; to controller.
REQ-010 Port: K  output  1  last-shift flag; to controller.
REQ-011 Port: Product  output  2*WIDTH  unsigned product.
REQ-012 Port: Valid  output  1  product-ready pulse.

Function
REQ-013 The block SHALL hold a 2*WIDTH+1-bit accumulator ACC, a WIDTH-bit multiplicand register MC, and a bit counter CNT of clog2(WIDTH) bits.
REQ-014 Load=1: ACC[2W:W] <= 0, ACC[W-1:0] <= Mplier, MC <= Mcand, CNT <= 0.
REQ-015 Ad=1 only: ACC[2W:W] <= ACC[2W-1:W] + MC as a W+1-bit sum with carry into ACC[2W]; ACC[W-1:0] unchanged.
REQ-016 Sh=1 only: ACC <= {1'b0, ACC[2W:1]} and CNT <= CNT+1, wrapping modulo 2^clog2(WIDTH).
REQ-017 Ad=1 and Sh=1 together: apply the add, then the shift, in one cycle; CNT increments.
REQ-018 Priority: Load overrides Ad and Sh; no input active holds all registers.
REQ-019 M SHALL equal ACC[0] combinationally.
REQ-020 K SHALL be combinational, 1 exactly when CNT == WIDTH-1, so the controller sees K=1 during the WIDTH-th shift.
REQ-021 After Load followed by WIDTH (Ad-if-M, Sh) iterations, ACC[2W-1:0] SHALL equal Mcand*Mplier and ACC[2W] SHALL be 0.
REQ-022 Mcand and Mplier changes after Load SHALL NOT affect the result.

Reset
REQ-023 Rst=1 at a rising edge SHALL clear ACC, MC, CNT and the product/valid registers, overriding Load/Ad/Sh.
REQ-024 After reset: M=0, K=0, Product=0, Valid=0.
REQ-025 Rst mid-operation SHALL abort the operation; the next result requires a fresh Load.

Configuration
REQ-026 Macro MULT_PRODUCT_REG_EN defined: a product register SHALL capture the post-shift ACC[2W-1:0] on the cycle where Sh=1 and K=1, and drive Product from it. Valid SHALL pulse 1 for the following cycle only. The register SHALL hold its value across later Loads until the next completion.
REQ-027 Macro undefined: Product SHALL equal ACC[2W-1:0] live, and Valid SHALL be tied 0.

Structure
REQ-028 Package mult_pkg SHALL hold MULT_WIDTH (16) and the counter-width constant derived via clog2.
REQ-029 Sub-module mult_bit_counter SHALL own CNT, with clear, increment and terminal-count (K) outputs; all other logic stays in mult_datapath.

Verification (WIDTH=4 unless stated)
REQ-030 Load with Mcand=13, Mplier=11, then drive controller-equivalent Ad/Sh sequence (8 cycles) -> K high on 4th Sh only; Product=143 (0x8F); with macro, Valid=1 for exactly one cycle after that shift.
REQ-031 Mcand=15, Mplier=15 -> Product=225, ACC[8]=0 at end; carry into ACC[8] observed on an intermediate add.
REQ-032 Mcand=0, Mplier=9 and Mcand=7, Mplier=0 -> Product=0; M sequence for Mplier=9 reads 1,0,0,1.
REQ-033 Rst asserted after 2nd Sh of 13*11 -> next cycle ACC=0, CNT=0, K=0, M=0, Product=0; a fresh Load of 3*5 then yields 15.
REQ-034 Load and Ad and Sh asserted together -> Load effect only, CNT=0; Mcand/Mplier toggled mid-operation -> result unchanged.
REQ-035 WIDTH=16: 65535*65535 -> Product=0xFFFE0001 after 16 shifts; K asserted only on the 16th shift.
